// File: rtl/fir_pkg.sv
// Shared types and default constants for the FIR load/result sequencer.
package fir_pkg;

  localparam int FIR_TAPS    = 16;
  localparam int FIR_BURST   = 4;
  localparam int FIR_TIMEOUT = 31;
  localparam int FIR_WORD_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIRE  = 2'd2,
    WAIT  = 2'd3
  } fir_seq_state_t;

endpackage

// File: rtl/fir_result_fifo.sv
// Two-entry result FIFO; the head entry is visible combinationally on data_o.
module fir_result_fifo
  import fir_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [FIR_WORD_W-1:0] data_i,
  input  logic                  pop_i,
  output logic [FIR_WORD_W-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  logic [FIR_WORD_W-1:0] mem_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;
  logic                  do_push;
  logic                  do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is dropped rather than corrupting the head.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      // Each entry is written only when the write pointer selects it.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_q[gi] <= '0;
        end else if (do_push && (wr_ptr_q == 1'(gi))) begin
          mem_q[gi] <= data_i;
        end
      end
    end
  endgenerate

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fir_sequencer.sv
// Turns a valid/ready word stream into FIR core load/wind/in_valid sequencing
// and collects the core's results into a ready/valid result stream.
module fir_sequencer
  import fir_pkg::*;
#(
  parameter int TAPS    = FIR_TAPS,
  parameter int BURST   = FIR_BURST,
  parameter int TIMEOUT = FIR_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [FIR_WORD_W-1:0] s_data,
  input  logic                  s_is_weight,
  output logic [FIR_WORD_W-1:0] fir_data,
  output logic                  fir_wind,
  output logic                  fir_load,
  output logic                  fir_in_valid,
  input  logic                  fir_out_valid,
  input  logic [FIR_WORD_W-1:0] fir_out,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [FIR_WORD_W-1:0] r_data,
  input  logic                  clr_err,
  output logic                  err
);

  localparam int CW = $clog2(TAPS + 1);
  localparam int BW = $clog2(BURST + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  fir_seq_state_t        state_q;
  logic                  live_q;
  logic                  is_weight_q;
  logic [CW-1:0]         w_cnt_q;
  logic [CW-1:0]         d_cnt_q;
  logic [CW-1:0]         w_cnt_d;
  logic [CW-1:0]         d_cnt_d;
  logic [BW-1:0]         burst_cnt_q;
  logic [WW-1:0]         wait_cnt_q;
  logic                  ov_prev_q;
  logic [FIR_WORD_W-1:0] fir_data_q;
  logic                  fir_wind_q;
  logic                  fir_load_q;
  logic                  fir_in_valid_q;
  logic                  err_q;

  logic                  fire_d;
  logic                  ov_edge;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  timeout;
  logic                  fifo_full;
  logic                  fifo_empty;

  // live_q keeps s_ready low while rst is held, even though the FIFO is empty.
  assign s_ready = live_q & (state_q == IDLE) & ~fifo_full;
  assign accept  = s_valid & s_ready;

  assign ov_edge = fir_out_valid & ~ov_prev_q;
  assign push    = (state_q == WAIT) & ov_edge;
  assign timeout = (state_q == WAIT) & ~ov_edge & (wait_cnt_q == WW'(TIMEOUT - 1));

  assign r_valid = ~fifo_empty;
  assign pop     = r_valid & r_ready;

  assign fir_data     = fir_data_q;
  assign fir_wind     = fir_wind_q;
  assign fir_load     = fir_load_q;
  assign fir_in_valid = fir_in_valid_q;
  assign err          = err_q;

  // Saturating post-increment of the tap counters for the word being shifted.
  always_comb begin
    w_cnt_d = w_cnt_q;
    d_cnt_d = d_cnt_q;
    if (is_weight_q) begin
      if (w_cnt_q != CW'(TAPS)) w_cnt_d = w_cnt_q + 1'b1;
    end else begin
      if (d_cnt_q != CW'(TAPS)) d_cnt_d = d_cnt_q + 1'b1;
    end
    fire_d = ~is_weight_q & (w_cnt_d == CW'(TAPS)) & (d_cnt_d == CW'(TAPS));
  end

  // Sequencer FSM with registered FIR-facing strobes and the sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      live_q         <= 1'b0;
      is_weight_q    <= 1'b0;
      w_cnt_q        <= '0;
      d_cnt_q        <= '0;
      burst_cnt_q    <= '0;
      wait_cnt_q     <= '0;
      ov_prev_q      <= 1'b0;
      fir_data_q     <= '0;
      fir_wind_q     <= 1'b0;
      fir_load_q     <= 1'b0;
      fir_in_valid_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      live_q     <= 1'b1;
      ov_prev_q  <= fir_out_valid;
      fir_wind_q <= 1'b0;
      fir_load_q <= 1'b0;

      if (timeout)      err_q <= 1'b1;
      else if (clr_err) err_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (accept) begin
            fir_data_q  <= s_data;
            fir_wind_q  <= s_is_weight;
            fir_load_q  <= ~s_is_weight;
            is_weight_q <= s_is_weight;
            state_q     <= SHIFT;
          end
        end
        SHIFT: begin
          w_cnt_q <= w_cnt_d;
          d_cnt_q <= d_cnt_d;
          if (fire_d) begin
            fir_in_valid_q <= 1'b1;
            burst_cnt_q    <= '0;
            state_q        <= FIRE;
          end else begin
            state_q <= IDLE;
          end
        end
        FIRE: begin
          if (burst_cnt_q == BW'(BURST - 1)) begin
            fir_in_valid_q <= 1'b0;
            wait_cnt_q     <= '0;
            state_q        <= WAIT;
          end else begin
            burst_cnt_q <= burst_cnt_q + 1'b1;
          end
        end
        WAIT: begin
          // The result word is pushed combinationally on the same edge.
          if (ov_edge || timeout) begin
            state_q <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fir_result_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (fir_out),
    .pop_i   (pop),
    .data_o  (r_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_fir_sequencer.sv
// Directed bench for fir_sequencer with a behavioural 16-tap FIR core stand-in.
module tb_fir_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic        s_is_weight = 1'b0;
  logic [15:0] fir_data;
  logic        fir_wind;
  logic        fir_load;
  logic        fir_in_valid;
  logic        fir_out_valid = 1'b0;
  logic [15:0] fir_out = '0;
  logic        r_valid;
  logic        r_ready = 1'b0;
  logic [15:0] r_data;
  logic        clr_err = 1'b0;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  fir_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_is_weight   (s_is_weight),
    .fir_data      (fir_data),
    .fir_wind      (fir_wind),
    .fir_load      (fir_load),
    .fir_in_valid  (fir_in_valid),
    .fir_out_valid (fir_out_valid),
    .fir_out       (fir_out),
    .r_valid       (r_valid),
    .r_ready       (r_ready),
    .r_data        (r_data),
    .clr_err       (clr_err),
    .err           (err)
  );

  always #5 clk = ~clk;

  // ---------------- FIR core stand-in ----------------
  logic [15:0] w_m [16];
  logic [15:0] d_m [16];
  logic        mute = 1'b0;
  int          run_len = 0;
  int          last_len = 0;
  int          n_bursts = 0;
  int          dly = 0;

  function automatic logic [15:0] dot();
    logic [15:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++) acc = acc + w_m[i] * d_m[i];
    return acc;
  endfunction

  always @(negedge clk) begin
    if (fir_wind) begin
      for (int i = 15; i > 0; i--) w_m[i] <= w_m[i-1];
      w_m[0] <= fir_data;
    end
    if (fir_load) begin
      for (int i = 15; i > 0; i--) d_m[i] <= d_m[i-1];
      d_m[0] <= fir_data;
    end
  end

  always @(posedge clk) begin
    fir_out_valid <= 1'b0;
    if (dly != 0) dly <= dly - 1;
    if (dly == 1) begin
      fir_out_valid <= 1'b1;
      fir_out       <= dot();
    end
    if (fir_in_valid) begin
      run_len <= run_len + 1;
    end else if (run_len != 0) begin
      last_len <= run_len;
      n_bursts <= n_bursts + 1;
      run_len  <= 0;
      if (!mute) dly <= 2;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] data, input logic is_w);
    int k;
    k = 0;
    @(negedge clk);
    while (!s_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("s_ready_before_send", {31'd0, s_ready}, 32'd1);
    s_valid     = 1'b1;
    s_data      = data;
    s_is_weight = is_w;
    @(negedge clk);
    s_valid = 1'b0;
    $display("send %s %0d", is_w ? "weight" : "sample", data);
  endtask

  task automatic get_result(input string tag, input logic [15:0] exp);
    int k;
    k = 0;
    while (!r_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_valid"}, {31'd0, r_valid}, 32'd1);
    chk({tag, "_data"}, {16'd0, r_data}, {16'd0, exp});
    $display("result %s r_data=%0d", tag, r_data);
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
    chk({tag, "_popped"}, {31'd0, r_valid}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    int nb;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_r_valid", {31'd0, r_valid}, 32'd0);
    chk("rst_in_valid", {31'd0, fir_in_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", {31'd0, s_ready}, 32'd1);

    // Weights of 1, samples 1..16 -> 136
    for (int i = 0; i < 16; i++) send(16'd1, 1'b1);
    repeat (8) @(negedge clk);
    chk("no_burst_for_weights", n_bursts, 0);
    for (int i = 1; i <= 15; i++) send(16'(i), 1'b0);
    repeat (8) @(negedge clk);
    chk("no_burst_unprimed", n_bursts, 0);
    chk("no_result_unprimed", {31'd0, r_valid}, 32'd0);
    send(16'd16, 1'b0);
    get_result("sum_1_16", 16'd136);
    chk("burst_len_1", last_len, 4);
    chk("burst_count_1", n_bursts, 1);
    chk("err_after_1", {31'd0, err}, 32'd0);

    // Streaming: window 2..17 -> 152
    send(16'd17, 1'b0);
    get_result("sum_2_17", 16'd152);
    chk("burst_count_2", n_bursts, 2);

    // Backpressure: two results buffered, s_ready drops
    send(16'd18, 1'b0);
    send(16'd19, 1'b0);
    repeat (40) @(negedge clk);
    chk("bp_r_valid", {31'd0, r_valid}, 32'd1);
    chk("bp_s_ready_low", {31'd0, s_ready}, 32'd0);
    chk("bp_head", {16'd0, r_data}, 32'd168);
    r_ready = 1'b1;
    @(negedge clk);
    chk("bp_second_valid", {31'd0, r_valid}, 32'd1);
    chk("bp_second", {16'd0, r_data}, 32'd184);
    @(negedge clk);
    r_ready = 1'b0;
    chk("bp_drained", {31'd0, r_valid}, 32'd0);
    chk("bp_s_ready_back", {31'd0, s_ready}, 32'd1);
    send(16'd20, 1'b0);
    get_result("sum_5_20", 16'd200);

    // Timeout with fir_out_valid held low
    mute = 1'b1;
    send(16'd21, 1'b0);
    k = 0;
    while (!fir_in_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("to_burst_seen", {31'd0, fir_in_valid}, 32'd1);
    k = 0;
    while (fir_in_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("to_burst_len", k, 4);
    repeat (30) @(negedge clk);
    chk("to_err_before", {31'd0, err}, 32'd0);
    @(negedge clk);
    chk("to_err_set", {31'd0, err}, 32'd1);
    chk("to_nothing_pushed", {31'd0, r_valid}, 32'd0);
    chk("to_s_ready_back", {31'd0, s_ready}, 32'd1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("clr_err", {31'd0, err}, 32'd0);
    mute = 1'b0;

    // Reset during FIRE
    send(16'd22, 1'b0);
    k = 0;
    while (!fir_in_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("mid_fire_in_valid", {31'd0, fir_in_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_in_valid", {31'd0, fir_in_valid}, 32'd0);
    chk("arst_load", {31'd0, fir_load}, 32'd0);
    chk("arst_r_valid", {31'd0, r_valid}, 32'd0);
    chk("arst_s_ready", {31'd0, s_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    nb = n_bursts;
    chk("rel_r_valid", {31'd0, r_valid}, 32'd0);

    // Samples alone must not fire after reset; then reload weights 0..15
    for (int i = 0; i < 16; i++) send(16'd2, 1'b0);
    repeat (10) @(negedge clk);
    chk("rel_samples_no_fire", n_bursts, nb);
    chk("rel_samples_no_result", {31'd0, r_valid}, 32'd0);
    for (int i = 0; i < 16; i++) send(16'(i), 1'b1);
    repeat (10) @(negedge clk);
    chk("rel_weights_no_fire", n_bursts, nb);
    send(16'd2, 1'b0);
    get_result("ramp_w_x2", 16'd240);
    chk("burst_len_ramp", last_len, 4);
    chk("err_final", {31'd0, err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
